// File: rtl/fb_plot_writer.sv
// Framebuffer write stage: FIFO-buffered pixel plots plus a full-screen clear sweep.
// Define FB_CLIP_EN to drop (and count) off-screen plot requests instead of writing them.
module fb_plot_writer #(
  parameter int H_RES      = 320,
  parameter int V_RES      = 240,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [9:0]        in_x,
  input  logic [8:0]        in_y,
  input  logic [2:0]        in_color,
  input  logic              clr_req,
  input  logic [2:0]        clr_color,
  output logic              busy,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [2:0]        fb_data,
  output logic              fb_we,
  output logic [7:0]        drop_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 3 + 9 + 10;
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
  localparam logic [31:0]       H_RES_V   = 32'(H_RES);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]        state;
  logic              clr_pending;
  logic              clr_run;
  logic [2:0]        clr_col;
  logic [ADDR_W-1:0] clr_addr;

  logic [ENT_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;
  logic              fifo_empty;

  logic              st_valid;
  logic [9:0]        st_x;
  logic [8:0]        st_y;
  logic [2:0]        st_color;
  logic [ADDR_W-1:0] lin_addr;
  logic              in_bounds;

  assign fifo_empty = (count == '0);
  assign in_ready   = rst && (count != FULL_CNT) && !clr_pending && (state == ST_IDLE);
  assign push       = in_valid && in_ready;
  assign pop        = (state == ST_IDLE) && !fifo_empty;
  assign busy       = !fifo_empty || clr_pending || (state == ST_CLEAR) || st_valid || fb_we;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {in_color, in_y, in_x};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
    end
  end

  // Pop stage: one entry per cycle, feeds the address adder.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_valid <= 1'b0;
      st_x     <= '0;
      st_y     <= '0;
      st_color <= '0;
    end else begin
      st_valid <= pop;
      if (pop) {st_color, st_y, st_x} <= mem[rptr];
    end
  end

  // y*H_RES + x as a sum of shifted rows, wrapping at ADDR_W bits.
  always_comb begin
    lin_addr = ADDR_W'(st_x);
    for (int unsigned i = 0; i < 32; i++) begin
      if (H_RES_V[i]) lin_addr = lin_addr + (ADDR_W'(st_y) << i);
    end
  end

`ifdef FB_CLIP_EN
  logic [7:0] drop_cnt;

  assign in_bounds  = (32'(st_x) < 32'(H_RES)) && (32'(st_y) < 32'(V_RES));
  assign drop_count = drop_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= '0;
    end else if (st_valid && !in_bounds && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`else
  assign in_bounds  = 1'b1;
  assign drop_count = '0;
`endif

  // clr_run stays low for one cycle after the last sweep write so that
  // in_ready only returns once that write has left the output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      clr_pending <= 1'b0;
      clr_run     <= 1'b0;
      clr_col     <= '0;
      clr_addr    <= '0;
      fb_we       <= 1'b0;
      fb_addr     <= '0;
      fb_data     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          fb_we <= st_valid && in_bounds;
          if (st_valid && in_bounds) begin
            fb_addr <= lin_addr;
            fb_data <= st_color;
          end
          if (clr_req && !clr_pending) begin
            clr_pending <= 1'b1;
            clr_col     <= clr_color;
          end
          if (clr_pending && fifo_empty && !st_valid) begin
            state       <= ST_CLEAR;
            clr_pending <= 1'b0;
            clr_run     <= 1'b1;
            clr_addr    <= '0;
          end
        end
        ST_CLEAR: begin
          if (clr_run) begin
            fb_we    <= 1'b1;
            fb_addr  <= clr_addr;
            fb_data  <= clr_col;
            clr_addr <= clr_addr + ADDR_W'(1);
            if (clr_addr == LAST_ADDR) clr_run <= 1'b0;
          end else begin
            fb_we <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          fb_we <= 1'b0;
        end
      endcase
    end
  end

endmodule
